instruction_fetch_unit: RTL

Sequencer that reads the instruction buffer. It drives the buffer's 6-bit read address and captures the 51-bit instruction word combinationally returned for it. It presents each word to the downstream decoder/systolic-array controller over a valid/ready handshake, at up to one instruction per cycle. A fetch run starts at a given address and ends on a HALT opcode or at the last address.

---
 rtl/sap_pkg.sv | 32 +++
 rtl/instruction_fetch_unit_if.sv | 31 +++
 rtl/instruction_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the instruction fetch path: bus widths, opcodes,
// fetch sequencer state encoding and an opcode-extract helper.
// Imported by the fetch interface, the fetch unit and its testbench.
package sap_pkg;

    localparam int ADDR_W = 6;   // instruction buffer address width
    localparam int INS_W  = 51;  // instruction word width
    localparam int OP_W   = 4;   // opcode field width (top bits of the word)

    // Highest buffer address; a run that reaches it stops there, no wrap.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(63);

    // Opcodes. Only HALT changes the fetch sequence; the rest are decoded downstream.
    localparam logic [OP_W-1:0] OP_NOP   = 4'b0000;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'b0001;
    localparam logic [OP_W-1:0] OP_MAC   = 4'b0010;
    localparam logic [OP_W-1:0] OP_STORE = 4'b0011;
    localparam logic [OP_W-1:0] HALT_OP  = 4'b1111;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Opcode sits in the most significant OP_W bits of the instruction word.
    function automatic logic [OP_W-1:0] opcode_of(input logic [INS_W-1:0] ins);
        return ins[INS_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of every non-clock/reset signal of the instruction fetch unit:
//   control  : start, start_addr, abort (in) / busy, done, fetch_count (out)
//   buffer   : ins_addr (out), ins_data (in, combinational return for ins_addr)
//   consumer : ins_out, ins_valid (out) / ins_ready (in)
// master = fetch unit side, slave = environment (buffer, consumer, controller).
interface instruction_fetch_unit_if;
    import sap_pkg::*;

    logic                start;
    logic [ADDR_W-1:0]   start_addr;
    logic                abort;
    logic [ADDR_W-1:0]   ins_addr;
    logic [INS_W-1:0]    ins_data;
    logic [INS_W-1:0]    ins_out;
    logic                ins_valid;
    logic                ins_ready;
    logic                busy;
    logic                done;
    logic [ADDR_W:0]     fetch_count;

    modport master (
        input  start, start_addr, abort, ins_data, ins_ready,
        output ins_addr, ins_out, ins_valid, busy, done, fetch_count
    );

    modport slave (
        output start, start_addr, abort, ins_data, ins_ready,
        input  ins_addr, ins_out, ins_valid, busy, done, fetch_count
    );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Purpose : sequences instruction-buffer reads and hands each word to the decoder.
// Latency : word at address A is on ins_out one cycle after ins_addr==A (slot free).
// Backpr. : ins_ready=0 with ins_valid=1 freezes ins_addr, ins_out and fetch_count.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : instruction_fetch_unit_if.master -- start/start_addr/abort control,
//                ins_addr/ins_data buffer read port, ins_out/ins_valid/ins_ready
//                consumer handshake, busy/done/fetch_count status.
module instruction_fetch_unit
    import sap_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus
);

    fetch_state_e        state_q,       state_d;
    logic [ADDR_W-1:0]   ins_addr_q,    ins_addr_d;
    logic [INS_W-1:0]    ins_out_q,     ins_out_d;
    logic                ins_valid_q,   ins_valid_d;
    logic                busy_q,        busy_d;
    logic                done_q,        done_d;
    logic [ADDR_W:0]     fetch_count_q, fetch_count_d;

    // Output register can take a new word when it is empty or being emptied now.
    logic slot_free;
    assign slot_free = !ins_valid_q || bus.ins_ready;

    logic is_halt;
    assign is_halt = (opcode_of(bus.ins_data) == HALT_OP);

    always_comb begin
        state_d       = state_q;
        ins_addr_d    = ins_addr_q;
        ins_out_d     = ins_out_q;
        ins_valid_d   = ins_valid_q;
        fetch_count_d = fetch_count_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                // abort is meaningless here, so start always wins.
                if (bus.start) begin
                    ins_addr_d    = bus.start_addr;
                    fetch_count_d = '0;
                    state_d       = FETCH;
                end
            end

            FETCH: begin
                if (bus.abort) begin
                    ins_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (slot_free) begin
                    ins_out_d     = bus.ins_data;
                    ins_valid_d   = 1'b1;
                    fetch_count_d = fetch_count_q + (ADDR_W+1)'(1);
                    // Last word of the run: park the address and wait for
                    // the consumer to take it.
                    if (is_halt || (ins_addr_q == LAST_ADDR)) begin
                        state_d = DRAIN;
                    end else begin
                        ins_addr_d = ins_addr_q + ADDR_W'(1);
                    end
                end
            end

            DRAIN: begin
                if (bus.abort) begin
                    ins_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (ins_valid_q && bus.ins_ready) begin
                    ins_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                ins_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ins_addr_q    <= '0;
            ins_out_q     <= '0;
            ins_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ins_addr_q    <= ins_addr_d;
            ins_out_q     <= ins_out_d;
            ins_valid_q   <= ins_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.ins_addr    = ins_addr_q;
    assign bus.ins_out     = ins_out_q;
    assign bus.ins_valid   = ins_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.fetch_count = fetch_count_q;

endmodule
